instr_fetch_unit: RTL and testbench

Instruction fetch unit that produces the fetch bundle consumed by the IF/ID pipeline latch (`Instr1_IF`, `Instr_PC_IF`, `Instr_PC_Plus4_IF`) and honours that latch's `STALL`. It generates sequential PCs and issues in-order requests to instruction memory. It buffers returned instructions in a small FIFO and handles branch redirects by flushing the FIFO and discarding in-flight responses. It sits between the branch predictor/resolution logic and the IF/ID latch.

---
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit. It issues in-order requests to instruction memory and
// pairs each response with its PC. Returned words are buffered in a small FIFO
// that feeds the IF/ID latch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RSP_VALID,
  input  logic [31:0] IMEM_RSP_DATA,
  output logic [31:0] Instr1_IF,
  output logic [31:0] Instr_PC_IF,
  output logic [31:0] Instr_PC_Plus4_IF,
  output logic        Instr_VALID
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d, outst_q, outst_d, drop_q, drop_d;
  logic [PW-1:0] fwr_q, fwr_d, frd_q, frd_d;
  logic [PW-1:0] twr_q, twr_d, trd_q, trd_d;

  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] tag_mem_q   [DEPTH];

  logic [CW:0] credit_sum;
  logic        accept, rsp_drop, push, pop, bubble;
  logic [31:0] head_pc;
  logic        unused_redir_lsb;

  assign unused_redir_lsb = &REDIRECT_PC[1:0];

  // Credit counts both in-flight requests and buffered words, so a response
  // always finds a free FIFO slot.
  assign credit_sum     = {1'b0, outst_q} + {1'b0, occ_q};
  assign IMEM_REQ_VALID = RESET & ~REDIRECT & (credit_sum < (CW+1)'(DEPTH));
  assign IMEM_ADDR      = fetch_pc_q;
  assign accept         = IMEM_REQ_VALID & IMEM_REQ_READY;
  assign rsp_drop       = IMEM_RSP_VALID & (REDIRECT | (drop_q != '0));
  assign push           = IMEM_RSP_VALID & ~rsp_drop;
  assign bubble         = (occ_q == '0) | REDIRECT;
  assign pop            = ~STALL & ~bubble;

  assign head_pc           = pc_mem_q[frd_q];
  assign Instr_VALID       = ~bubble;
  assign Instr1_IF         = bubble ? 32'd0 : instr_mem_q[frd_q];
  assign Instr_PC_IF       = bubble ? 32'd0 : head_pc;
  assign Instr_PC_Plus4_IF = bubble ? 32'd0 : head_pc + 32'd4;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    outst_d    = outst_q + CW'(accept) - CW'(IMEM_RSP_VALID);
    drop_d     = drop_q;
    fwr_d      = fwr_q;
    frd_d      = frd_q;
    twr_d      = twr_q;
    trd_d      = trd_q;
    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      twr_d      = twr_q + 1'b1;
    end
    if (IMEM_RSP_VALID) trd_d = trd_q + 1'b1;
    // The tag queue survives a redirect: stale responses still pop their tags.
    if (REDIRECT) begin
      fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
      occ_d      = '0;
      fwr_d      = '0;
      frd_d      = '0;
      drop_d     = outst_q - CW'(IMEM_RSP_VALID);
    end else begin
      if (IMEM_RSP_VALID && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (push) fwr_d = fwr_q + 1'b1;
      if (pop)  frd_d = frd_q + 1'b1;
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      fwr_q      <= '0;
      frd_q      <= '0;
      twr_q      <= '0;
      trd_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fwr_q      <= fwr_d;
      frd_q      <= frd_d;
      twr_q      <= twr_d;
      trd_q      <= trd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) tag_mem_q[twr_q] <= fetch_pc_q;
    if (push) begin
      instr_mem_q[fwr_q] <= IMEM_RSP_DATA;
      pc_mem_q[fwr_q]    <= tag_mem_q[trd_q];
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a latency-programmable memory model plus
// an in-order expected-PC tracker for every bundle the IF/ID latch consumes.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        CLK = 1'b0;
  logic        RESET, STALL, REDIRECT, IMEM_REQ_VALID, IMEM_REQ_READY;
  logic        IMEM_RSP_VALID, Instr_VALID;
  logic [31:0] REDIRECT_PC, IMEM_ADDR, IMEM_RSP_DATA;
  logic [31:0] Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .IMEM_REQ_VALID(IMEM_REQ_VALID),
    .IMEM_REQ_READY(IMEM_REQ_READY), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_RSP_VALID(IMEM_RSP_VALID), .IMEM_RSP_DATA(IMEM_RSP_DATA),
    .Instr1_IF(Instr1_IF), .Instr_PC_IF(Instr_PC_IF),
    .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF), .Instr_VALID(Instr_VALID)
  );

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_cons = 0;
  int          c0;
  logic [31:0] exp_pc;
  logic        last_vld, last_reqv;
  logic [31:0] last_pc, last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    logic        acc, rsp;
    logic [31:0] aaddr;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      IMEM_RSP_VALID = 1'b1;
      IMEM_RSP_DATA  = mq_addr[0] ^ 32'h1234_0000;
    end else begin
      IMEM_RSP_VALID = 1'b0;
      IMEM_RSP_DATA  = 32'd0;
    end
    #1;
    last_vld  = Instr_VALID;
    last_pc   = Instr_PC_IF;
    last_reqv = IMEM_REQ_VALID;
    last_addr = IMEM_ADDR;
    if (REDIRECT) chk("redirect_bubble", 32'(Instr_VALID), 32'd0);
    if (!Instr_VALID) begin
      chk("bubble_zero", Instr1_IF | Instr_PC_IF | Instr_PC_Plus4_IF, 32'd0);
    end else if (!STALL && !REDIRECT) begin
      chk("pc", Instr_PC_IF, exp_pc);
      chk("instr", Instr1_IF, exp_pc ^ 32'h1234_0000);
      chk("plus4", Instr_PC_Plus4_IF, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    acc   = IMEM_REQ_VALID & IMEM_REQ_READY;
    aaddr = IMEM_ADDR;
    rsp   = IMEM_RSP_VALID;
    @(posedge CLK);
    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (acc) begin
      mq_addr.push_back(aaddr);
      mq_due.push_back(cyc + lat);
    end
    cyc++;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'd0;
    IMEM_REQ_READY = 1'b1; IMEM_RSP_VALID = 1'b0; IMEM_RSP_DATA = 32'd0;
    exp_pc = RPC;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_reqv", 32'(IMEM_REQ_VALID), 32'd0);
    chk("rst_addr", IMEM_ADDR, RPC);
    chk("rst_vld", 32'(Instr_VALID), 32'd0);
    chk("rst_bundle", Instr1_IF | Instr_PC_IF | Instr_PC_Plus4_IF, 32'd0);
    @(negedge CLK);

    // Reset release and 1-cycle streaming, with a short READY gap
    RESET = 1'b1;
    tick();
    chk("first_req", 32'(last_reqv), 32'd1);
    chk("first_addr", last_addr, RPC);
    tick();
    chk("lat_c1_bubble", 32'(last_vld), 32'd0);
    tick();
    chk("lat_c2_valid", 32'(last_vld), 32'd1);
    repeat (6) tick();
    IMEM_REQ_READY = 1'b0;
    repeat (2) tick();
    IMEM_REQ_READY = 1'b1;
    repeat (6) tick();
    chk("stream_count", 32'(n_cons), 32'd13);

    // STALL backpressure: credit closes after two more accepts
    STALL = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stall_head", last_pc, exp_pc);
      chk("stall_reqv", 32'(last_reqv), (k < 2) ? 32'd1 : 32'd0);
    end
    STALL = 1'b0;
    c0 = n_cons;
    repeat (8) tick();
    chk("stall_drain", 32'(n_cons - c0 >= 6), 32'd1);

    // Redirect with 3-cycle memory and requests in flight
    lat = 3;
    repeat (10) tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0103; exp_pc = 32'h0000_0100;
    tick();
    chk("redir_reqv", 32'(last_reqv), 32'd0);
    chk("redir_outs", last_pc, 32'd0);
    REDIRECT = 1'b0;
    c0 = n_cons;
    tick();
    chk("redir_addr", last_addr, 32'h0000_0100);
    chk("redir_reqv_next", 32'(last_reqv), 32'd1);
    repeat (10) tick();
    chk("redir_progress", 32'(n_cons - c0 >= 3), 32'd1);

    // Redirect coinciding with a response and a pop; PC wraps through zero
    lat = 1;
    repeat (10) tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFF8; exp_pc = 32'hFFFF_FFF8;
    tick();
    chk("wrap_redir_reqv", 32'(last_reqv), 32'd0);
    REDIRECT = 1'b0;
    c0 = n_cons;
    repeat (6) tick();
    chk("wrap_count", 32'(n_cons - c0), 32'd4);

    // Asynchronous reset mid-stream with buffered and in-flight words
    lat = 3;
    repeat (6) tick();
    STALL = 1'b1;
    repeat (2) tick();
    #2;
    RESET = 1'b0;
    IMEM_RSP_VALID = 1'b0;
    #1;
    chk("arst_reqv", 32'(IMEM_REQ_VALID), 32'd0);
    chk("arst_vld", 32'(Instr_VALID), 32'd0);
    chk("arst_bundle", Instr1_IF | Instr_PC_IF | Instr_PC_Plus4_IF, 32'd0);
    chk("arst_addr", IMEM_ADDR, RPC);
    mq_addr.delete();
    mq_due.delete();
    @(negedge CLK);
    STALL = 1'b0;
    lat = 1;
    repeat (2) tick();
    RESET = 1'b1;
    exp_pc = RPC;
    c0 = n_cons;
    repeat (6) tick();
    chk("post_reset_count", 32'(n_cons - c0), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
